// File: rtl/quad_step_decoder_pkg.sv
// quad_pkg: shared state type, direction constants and Gray-order lookup for the quadrature decoder
package quad_pkg;
  typedef enum logic [0:0] {INIT, RUN} state_t;
  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;
  function automatic logic [1:0] gray_next(input logic [1:0] s);
    return {s[0], ~s[1]};
  endfunction
endpackage

// File: rtl/quad_step_decoder_if.sv
// quad_step_decoder_if: raw encoder inputs, controls and decoded outputs of the quadrature front end
interface quad_step_decoder_if #(parameter int ERR_W = 8);
  logic a_in;
  logic b_in;
  logic en;
  logic clr_err;
  logic step;
  logic dir;
  logic err;
  logic [ERR_W-1:0] err_cnt;
  logic [1:0] ab_filt;
  logic ready;
  modport master (output a_in, b_in, en, clr_err, input step, dir, err, err_cnt, ab_filt, ready);
  modport slave (input a_in, b_in, en, clr_err, output step, dir, err, err_cnt, ab_filt, ready);
endinterface

// File: rtl/quad_step_decoder_sync_filter.sv
// quad_step_decoder_sync_filter: one channel synchronizer followed by a persistence glitch filter
module quad_step_decoder_sync_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic filt,
  output logic idle
);
  localparam int CW = $clog2(FILT_CYCLES + 1);
  logic [SYNC_STAGES-1:0] sync;
  logic [CW-1:0] cnt;
  logic lvl;
  assign lvl = sync[SYNC_STAGES-1];
  assign idle = cnt == '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= '0;
      filt <= 1'b0;
      cnt <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], raw};
      if (lvl == filt) cnt <= '0;
      else if (cnt == CW'(FILT_CYCLES - 1)) begin
        filt <= lvl;
        cnt <= '0;
      end else cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/quad_step_decoder.sv
// quad_step_decoder: filters A/B, waits for a stable power-on position, then decodes Gray steps and errors
module quad_step_decoder
  import quad_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYCLES = 4,
  parameter int ERR_W = 8
) (
  input logic clk,
  input logic rst,
  quad_step_decoder_if.slave bus
);
  localparam int SW = $clog2(FILT_CYCLES + 1);
  state_t state;
  logic [SW-1:0] st_cnt;
  logic [1:0] prev;
  logic [1:0] ab;
  logic [ERR_W-1:0] err_cnt;
  logic fa, fb, idle_a, idle_b;
  logic step, dir, err, ready;
  logic go, fwd, rev, dbl;
  quad_step_decoder_sync_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_CYCLES(FILT_CYCLES)) u_a (
    .clk(clk), .rst(rst), .raw(bus.a_in), .filt(fa), .idle(idle_a)
  );
  quad_step_decoder_sync_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_CYCLES(FILT_CYCLES)) u_b (
    .clk(clk), .rst(rst), .raw(bus.b_in), .filt(fb), .idle(idle_b)
  );
  assign ab = {fa, fb};
  assign go = state == RUN && bus.en;
  assign fwd = ab == gray_next(prev);
  assign rev = prev == gray_next(ab);
  assign dbl = (ab ^ prev) == 2'b11;
  // prev tracks even while disabled so re-enabling never replays old movement
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= INIT;
      st_cnt <= '0;
      prev <= 2'b00;
      step <= 1'b0;
      dir <= DIR_UP;
      err <= 1'b0;
      err_cnt <= '0;
      ready <= 1'b0;
    end else begin
      prev <= ab;
      step <= go && (fwd || rev);
      err <= go && dbl;
      if (go && (fwd || rev)) dir <= fwd ? DIR_UP : DIR_DN;
      err_cnt <= bus.clr_err ? ERR_W'(go && dbl) :
                 (go && dbl && !(&err_cnt)) ? err_cnt + 1'b1 : err_cnt;
      if (state == INIT) begin
        if (idle_a && idle_b) begin
          if (st_cnt == SW'(FILT_CYCLES - 1)) begin
            state <= RUN;
            ready <= 1'b1;
          end else st_cnt <= st_cnt + 1'b1;
        end else st_cnt <= '0;
      end
    end
  end
  assign bus.step = step;
  assign bus.dir = dir;
  assign bus.err = err;
  assign bus.err_cnt = err_cnt;
  assign bus.ab_filt = ab;
  assign bus.ready = ready;
endmodule

// File: tb/tb_quad_step_decoder.sv
// tb_quad_step_decoder: directed stimulus with a queued scoreboard checked by an independent monitor
module tb_quad_step_decoder;
  localparam int LAT = 7;
  typedef struct {
    logic is_err;
    logic dir;
    logic [7:0] cnt;
    int cyc;
  } ev_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int cyc = 0;
  int checks = 0;
  int fails = 0;
  int ud = 0;
  int base;
  ev_t q[$];
  quad_step_decoder_if #(.ERR_W(8)) bus();
  quad_step_decoder #(.SYNC_STAGES(2), .FILT_CYCLES(4), .ERR_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (bus.step || bus.err) begin
      checks++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_event cyc=%0d step=%b err=%b dir=%b required none", cyc, bus.step, bus.err, bus.dir);
      end else begin
        ev_t e;
        e = q.pop_front();
        if (bus.err != e.is_err || bus.step == e.is_err || cyc != e.cyc || bus.dir != e.dir ||
            (e.is_err && bus.err_cnt != e.cnt)) begin
          fails++;
          $display("FAIL event cyc=%0d step=%b err=%b dir=%b cnt=%0d required cyc=%0d err=%b dir=%b cnt=%0d",
                   cyc, bus.step, bus.err, bus.dir, bus.err_cnt, e.cyc, e.is_err, e.dir, e.cnt);
        end
        if (bus.step) ud += bus.dir ? 1 : -1;
      end
    end
  end
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s got=%0d required=%0d", name, got, exp);
    end
  endtask
  task automatic set_ab(input logic [1:0] v);
    bus.a_in = v[1];
    bus.b_in = v[0];
  endtask
  task automatic push(input logic is_err, input logic d, input logic [7:0] c);
    q.push_back('{is_err: is_err, dir: d, cnt: c, cyc: cyc + LAT});
  endtask
  task automatic move(input logic [1:0] v, input logic d);
    set_ab(v);
    push(1'b0, d, 8'd0);
    tick(10);
    chk("ab_filt_hold", int'(bus.ab_filt), int'(v));
  endtask
  initial begin
    bus.en = 1'b1;
    bus.clr_err = 1'b0;
    set_ab(2'b11);
    tick(3);
    chk("rst_ready", int'(bus.ready), 0);
    chk("rst_ab_filt", int'(bus.ab_filt), 0);
    chk("rst_dir", int'(bus.dir), 1);
    chk("rst_err_cnt", int'(bus.err_cnt), 0);
    chk("rst_step_err", int'({bus.step, bus.err}), 0);
    rst = 1'b0;
    tick(20);
    chk("init_ready", int'(bus.ready), 1);
    chk("init_ab_filt", int'(bus.ab_filt), 3);
    chk("init_err_cnt", int'(bus.err_cnt), 0);
    move(2'b10, 1'b1);
    move(2'b00, 1'b1);
    base = ud;
    move(2'b01, 1'b1);
    move(2'b11, 1'b1);
    move(2'b10, 1'b1);
    move(2'b00, 1'b1);
    chk("fwd_count", ud - base, 4);
    base = ud;
    move(2'b10, 1'b0);
    move(2'b11, 1'b0);
    move(2'b01, 1'b0);
    move(2'b00, 1'b0);
    chk("rev_count", ud - base, -4);
    bus.a_in = 1'b1;
    tick(3);
    bus.a_in = 1'b0;
    tick(10);
    chk("glitch_ab_filt", int'(bus.ab_filt), 0);
    set_ab(2'b11);
    push(1'b1, 1'b0, 8'd1);
    tick(10);
    chk("illegal_err_cnt", int'(bus.err_cnt), 1);
    chk("illegal_dir", int'(bus.dir), 0);
    set_ab(2'b00);
    push(1'b1, 1'b0, 8'd1);
    tick(LAT - 1);
    bus.clr_err = 1'b1;
    tick(1);
    bus.clr_err = 1'b0;
    tick(10);
    chk("clr_with_err", int'(bus.err_cnt), 1);
    bus.clr_err = 1'b1;
    tick(1);
    bus.clr_err = 1'b0;
    tick(1);
    chk("clr_alone", int'(bus.err_cnt), 0);
    bus.en = 1'b0;
    set_ab(2'b01);
    tick(10);
    set_ab(2'b11);
    tick(10);
    set_ab(2'b10);
    tick(10);
    bus.en = 1'b1;
    tick(10);
    chk("en_dir_held", int'(bus.dir), 0);
    chk("en_ab_filt", int'(bus.ab_filt), 2);
    move(2'b00, 1'b1);
    chk("en_dir_after", int'(bus.dir), 1);
    bus.a_in = 1'b1;
    tick(3);
    rst = 1'b1;
    tick(1);
    chk("midrst_ready", int'(bus.ready), 0);
    chk("midrst_ab_filt", int'(bus.ab_filt), 0);
    rst = 1'b0;
    tick(20);
    chk("midrst_ready_again", int'(bus.ready), 1);
    chk("midrst_ab_filt_again", int'(bus.ab_filt), 2);
    tick(5);
    while (q.size() > 0) begin
      ev_t e;
      e = q.pop_front();
      checks++;
      fails++;
      $display("FAIL missing_event required cyc=%0d err=%b dir=%b", e.cyc, e.is_err, e.dir);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/quad_step_decoder.md
Name: quad_step_decoder

Overview:
- Upstream front end for the 4-bit up/down counter stage.
- Takes raw asynchronous quadrature signals A/B from an encoder or push-button pair, and synchronizes and glitch-filters them.
- Decodes Gray-code transitions into a single-cycle `step` strobe plus a `dir` level (1 = up, 0 = down) for the counter.
- Flags illegal double transitions and keeps a saturating error count.

Parameters:
- SYNC_STAGES, 2, number of flip-flops in each input synchronizer (minimum 2).
- FILT_CYCLES, 4, consecutive cycles a synchronized level must persist before it is accepted (minimum 1).
- ERR_W, 8, width of the error counter.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- a_in  in  1  raw channel A, asynchronous
- b_in  in  1  raw channel B, asynchronous
- en  in  1  decode enable; 0 suppresses step/err outputs only
- clr_err  in  1  synchronous clear of err_cnt
- step  out  1  one-cycle strobe per valid quarter-step
- dir  out  1  direction of the last valid step; 1 = up, 0 = down
- err  out  1  one-cycle strobe on an illegal transition
- err_cnt  out  ERR_W  saturating count of illegal transitions
- ab_filt  out  2  filtered {A,B} state
- ready  out  1  high once the INIT phase has completed

Behaviour:
- Reset: all synchronizer flops, filter counters and filtered state go to 0. Outputs reset to step=0, dir=1, err=0, err_cnt=0, ab_filt=2'b00, ready=0. FSM goes to INIT.
- Synchronizer: each channel passes through a SYNC_STAGES-deep shift register; the last stage is the synchronized level.
- Filter, per channel:
  - The counter (width `$clog2(FILT_CYCLES+1)`) resets to 0 whenever the synchronized level equals the filtered level.
  - Otherwise it increments each cycle.
  - When it equals FILT_CYCLES-1 while the levels still differ, the filtered level takes the synchronized level and the counter returns to 0.
  - Any single-cycle mismatch shorter than FILT_CYCLES is discarded.
- FSM state INIT:
  - The filter runs, but transitions are not decoded; step and err are forced to 0.
  - Leave for RUN once both filter counters have been 0 for FILT_CYCLES consecutive cycles, i.e. both channels are stable. ready goes to 1 on entry to RUN.
  - This absorbs the encoder's power-on position without producing a false error.
- FSM state RUN:
  - A registered prev state holds the last ab_filt value.
  - Each cycle, compare prev with ab_filt:
    - Forward sequence 00->01->11->10->00: step=1, dir=1.
    - Reverse sequence 00->10->11->01->00: step=1, dir=0.
    - Both bits changed: err=1, no step, dir unchanged.
    - No change: step=0, err=0.
  - prev is always updated to ab_filt.
- Latency: a clean edge on a_in produces step exactly SYNC_STAGES+FILT_CYCLES+1 rising clk edges later (7 with defaults).
- en=0: synchronizer, filter and prev continue to track; step and err are held at 0; dir and err_cnt do not change. Re-asserting en never produces a step for movement that occurred while disabled.
- err_cnt:
  - Increments by 1 on each err strobe and saturates at all-ones.
  - clr_err alone sets it to 0.
  - clr_err in the same cycle as an err strobe sets it to 1.
- Within a channel, at most one filtered change per cycle. A and B filtered simultaneously in the same cycle counts as an illegal transition.
- rst asserted mid-operation: all state returns to reset values on the next edge, and a pending step is lost.
- Outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Shared package quad_pkg holds:
  - state enum {INIT, RUN}
  - constants DIR_UP=1'b1 and DIR_DN=1'b0
  - a 2-bit Gray-order function or next-state table used for the forward/reverse lookup
- One sub-module is natural: sync_filter (one channel, holding SYNC_STAGES and FILT_CYCLES), instantiated twice for A and B.
- Decode, FSM and err_cnt live in the top level.

Test Plan:
- Reset with a_in=b_in=1 held, wait 20 cycles -> ready=1, ab_filt=2'b11, err=0, err_cnt=0, no step.
- In RUN with en=1, apply forward sequence 00,01,11,10,00, each level held 10 cycles -> 4 step strobes, each dir=1, first at 7 cycles after the input change. Feeding these to the up/down counter gives a count of 4.
- Same setup with reverse sequence 00,10,11,01,00 -> 4 step strobes with dir=0.
- Pulse a_in high for 3 cycles (shorter than FILT_CYCLES=4) -> ab_filt unchanged, no step, no err.
- Switch {a_in,b_in} from 00 to 11 on the same edge -> single err strobe, err_cnt=1, no step, dir unchanged. Then assert clr_err in the same cycle as a second illegal jump -> err_cnt=1.
- With en=0, apply 3 forward transitions, then set en=1 -> no step, dir unchanged. The next forward transition gives a single step with dir=1.
